// File: rtl/hilo_sequencer_if.sv
// Handshake bundle between Control, the Mult/Div units and the HI/LO sequencer.
// Latency: none (wires only).
// Backpressure: req_ready/hilo_stall travel back to Control over this bundle.
// Ports: request side (req_valid, req_op, abort, hilo_rd), unit status (MultDone,
// DivDone, Div0), and sequencer outputs (start pulses, mux selects, HI/LO write
// enables, completion/exception pulses, stall).
interface hilo_sequencer_if;
   logic req_valid;
   logic req_op;
   logic abort;
   logic hilo_rd;
   logic MultDone;
   logic DivDone;
   logic Div0;
   logic req_ready;
   logic busy;
   logic MultCtrl;
   logic DivCtrl;
   logic HICtrl;
   logic LOCtrl;
   logic WriteHI;
   logic WriteLO;
   logic done;
   logic div0_exc;
   logic timeout_exc;
   logic hilo_stall;

   // Control / unit side
   modport master (
      output req_valid, req_op, abort, hilo_rd, MultDone, DivDone, Div0,
      input  req_ready, busy, MultCtrl, DivCtrl, HICtrl, LOCtrl,
      input  WriteHI, WriteLO, done, div0_exc, timeout_exc, hilo_stall
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_op, abort, hilo_rd, MultDone, DivDone, Div0,
      output req_ready, busy, MultCtrl, DivCtrl, HICtrl, LOCtrl,
      output WriteHI, WriteLO, done, div0_exc, timeout_exc, hilo_stall
   );
endinterface

// File: rtl/hilo_sequencer.sv
// Sequences one MULT/DIV: launch unit, wait for done, commit HI/LO; div0/timeout pulses.
// Latency: accept c0, start pulse c1, WAIT from c2, commit the cycle after the done flag.
// Backpressure: req_ready only in IDLE; hilo_stall = hilo_rd & busy (combinational).
// Ports: clock, reset (sync, active-high), bus (hilo_sequencer_if.slave) carrying the
// request, unit status, start pulses, mux selects, write enables and exception pulses.
module hilo_sequencer #(
   parameter int TIMEOUT_CYCLES = 40
) (
   input logic        clock,
   input logic        reset,
   hilo_sequencer_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_ERR    = 3'd4;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic          op;        // latched request: 0=MULT, 1=DIV
   logic          mux_sel;   // HI/LO mux select, holds until the next accept
   logic          err_div0;  // distinguishes the two ERR causes
   logic [CW-1:0] cnt;
   logic          sel_done;

   // Only the launched unit's done flag counts.
   assign sel_done = op ? bus.DivDone : bus.MultDone;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.req_valid) state_nxt = S_LAUNCH;
         // The start pulse is already out; abort only skips the wait.
         S_LAUNCH: state_nxt = bus.abort ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (bus.abort)               state_nxt = S_IDLE;
            else if (op && bus.Div0)     state_nxt = S_ERR;
            else if (sel_done)           state_nxt = S_COMMIT;
            else if (cnt == CNT_LAST)    state_nxt = S_ERR;
            else                         state_nxt = S_WAIT;
         end
         S_COMMIT: state_nxt = S_IDLE;
         S_ERR:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         op       <= 1'b0;
         mux_sel  <= 1'b0;
         err_div0 <= 1'b0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && bus.req_valid) begin
            op      <= bus.req_op;
            mux_sel <= ~bus.req_op;
         end
         if (state == S_LAUNCH)
            cnt <= '0;
         else if (state == S_WAIT)
            cnt <= cnt + CW'(1);
         // Div0 outranks both done and timeout, so sampling it every WAIT
         // cycle leaves the right cause latched whenever ERR is entered.
         if (state == S_WAIT)
            err_div0 <= op & bus.Div0;
      end
   end

   // Moore outputs
   assign bus.req_ready   = (state == S_IDLE);
   assign bus.busy        = (state == S_LAUNCH) || (state == S_WAIT) ||
                            (state == S_COMMIT) || (state == S_ERR);
   assign bus.MultCtrl    = (state == S_LAUNCH) && !op;
   assign bus.DivCtrl     = (state == S_LAUNCH) &&  op;
   // Reset clears the select so every output is low out of reset; from the
   // first accept onward it equals ~op.
   assign bus.HICtrl      = mux_sel;
   assign bus.LOCtrl      = mux_sel;
   assign bus.WriteHI     = (state == S_COMMIT);
   assign bus.WriteLO     = (state == S_COMMIT);
   assign bus.done        = (state == S_COMMIT);
   assign bus.div0_exc    = (state == S_ERR) &&  err_div0;
   assign bus.timeout_exc = (state == S_ERR) && !err_div0;
   assign bus.hilo_stall  = bus.hilo_rd && bus.busy;

endmodule

// File: tb/tb_hilo_sequencer.sv
module tb_hilo_sequencer;
   localparam int TO = 40;

   localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WAIT = 2, PH_COMMIT = 3, PH_DIV0 = 4, PH_TO = 5;
   localparam int K_ABORT = 0, K_DIV0 = 1, K_COMMIT = 2, K_TO = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   hilo_sequencer_if bus();

   hilo_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Per-WAIT-cycle stimulus, indexed by WAIT cycle number.
   bit md [TO];
   bit dd [TO];
   bit d0a[TO];
   bit ab [TO];
   bit rd_mode = 1'b0;
   bit sel_exp = 1'b0;

   // Observations from the last run_op, for scenario-level checks.
   int obs_mc, obs_dc, obs_done, obs_wr, obs_d0, obs_to, obs_stall;
   int obs_done_i, obs_to_i, obs_d0_i;

   function automatic logic [11:0] act_vec();
      return {bus.req_ready, bus.busy, bus.MultCtrl, bus.DivCtrl, bus.HICtrl, bus.LOCtrl,
              bus.WriteHI, bus.WriteLO, bus.done, bus.div0_exc, bus.timeout_exc, bus.hilo_stall};
   endfunction

   // Expected output word for a phase of an operation's timeline.
   function automatic logic [11:0] exp_vec(int ph, bit sel, bit rd);
      bit rr, bz, mc, dc, wr, dn, de, te;
      rr = (ph == PH_IDLE);
      bz = !rr;
      mc = 0; dc = 0; wr = 0; dn = 0; de = 0; te = 0;
      if (ph == PH_COMMIT) begin wr = 1; dn = 1; end
      if (ph == PH_DIV0) de = 1;
      if (ph == PH_TO) te = 1;
      return {rr, bz, mc, dc, sel, sel, wr, wr, dn, de, te, rd & bz};
   endfunction

   // Outcome from the rules: first WAIT cycle where abort, div0 (DIV only),
   // the selected done flag, or the last allowed WAIT cycle applies.
   function automatic void model(input bit op, input bit ab_l, output int wend, output int kind);
      wend = -1;
      kind = K_ABORT;
      if (ab_l) return;
      for (int w = 0; w < TO; w++) begin
         wend = w;
         if (ab[w])                  begin kind = K_ABORT;  return; end
         if (op && d0a[w])           begin kind = K_DIV0;   return; end
         if (op ? dd[w] : md[w])     begin kind = K_COMMIT; return; end
         if (w == TO - 1)            begin kind = K_TO;     return; end
      end
   endfunction

   task automatic clear_stim();
      for (int w = 0; w < TO; w++) begin md[w] = 0; dd[w] = 0; d0a[w] = 0; ab[w] = 0; end
   endtask

   function automatic bit rd_val();
      return rd_mode ? 1'b1 : 1'($urandom_range(0, 1));
   endfunction

   // Entry/exit: 1 time unit after a rising edge, DUT in IDLE.
   task automatic run_op(input bit op, input bit ab_l, input string name);
      int wend, kind, last, ph;
      bit sel, rd;
      logic [11:0] exp, act;
      model(op, ab_l, wend, kind);
      last = wend + 3;
      obs_mc = 0; obs_dc = 0; obs_done = 0; obs_wr = 0; obs_d0 = 0; obs_to = 0; obs_stall = 0;
      obs_done_i = -1; obs_to_i = -1; obs_d0_i = -1;
      for (int i = 0; i <= last; i++) begin
         rd = rd_val();
         bus.hilo_rd = rd;
         bus.req_valid = (i == 0);
         bus.req_op = (i == 0) ? op : 1'($urandom_range(0, 1));
         bus.abort = 0; bus.MultDone = 0; bus.DivDone = 0; bus.Div0 = 0;
         if (i == 1) bus.abort = ab_l;
         if (i >= 2 && i < last) begin
            bus.MultDone = md[i-2]; bus.DivDone = dd[i-2];
            bus.Div0 = d0a[i-2];    bus.abort = ab[i-2];
         end
         sel = (i == 0) ? sel_exp : ~op;
         if (i == 0) ph = PH_IDLE;
         else if (i == 1 && !(ab_l && i == last)) ph = PH_LAUNCH;
         else if (i < last) ph = PH_WAIT;
         else if (kind == K_COMMIT) ph = PH_COMMIT;
         else if (kind == K_DIV0) ph = PH_DIV0;
         else if (kind == K_TO) ph = PH_TO;
         else ph = PH_IDLE;
         #1;
         exp = exp_vec(ph, sel, rd);
         if (ph == PH_LAUNCH) exp[9:8] = op ? 2'b01 : 2'b10;
         act = act_vec();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b want %b (rr bz mc dc hi lo whi wlo dn d0 to st)",
                     name, i, act, exp);
         end
         obs_mc += int'(bus.MultCtrl); obs_dc += int'(bus.DivCtrl);
         obs_wr += int'(bus.WriteHI | bus.WriteLO); obs_stall += int'(bus.hilo_stall);
         if (bus.done === 1'b1)        begin obs_done++; obs_done_i = i; end
         if (bus.div0_exc === 1'b1)    begin obs_d0++;   obs_d0_i = i; end
         if (bus.timeout_exc === 1'b1) begin obs_to++;   obs_to_i = i; end
         @(posedge clock); #1;
      end
      sel_exp = ~op;
      bus.req_valid = 0; bus.abort = 0; bus.MultDone = 0; bus.DivDone = 0; bus.Div0 = 0;
   endtask

   task automatic test_reset();
      logic [11:0] act;
      bus.req_valid = 0; bus.req_op = 0; bus.abort = 1; bus.hilo_rd = 1;
      bus.MultDone = 0; bus.DivDone = 0; bus.Div0 = 0;
      reset = 1;
      repeat (2) @(posedge clock);
      #1;
      act = act_vec();
      checks++;
      if (act !== 12'b1000_0000_0000) begin
         errors++; $display("FAIL reset_state: got %b want %b", act, 12'b1000_0000_0000);
      end
      reset = 0;
      // abort with no request in IDLE changes nothing
      @(posedge clock); #1;
      act = act_vec();
      checks++;
      if (act !== 12'b1000_0000_0000) begin
         errors++; $display("FAIL idle_abort: got %b want %b", act, 12'b1000_0000_0000);
      end
      bus.abort = 0; bus.hilo_rd = 0;
      sel_exp = 0;
   endtask

   task automatic test_mult();
      clear_stim(); md[33] = 1; dd[20] = 1; d0a[25] = 1;
      run_op(0, 0, "mult");
      checks++;
      if (obs_mc != 1 || obs_dc != 0) begin
         errors++; $display("FAIL mult_start: got mc=%0d dc=%0d want mc=1 dc=0", obs_mc, obs_dc);
      end
      checks++;
      if (obs_done != 1 || obs_done_i != 36) begin
         errors++; $display("FAIL mult_done_cycle: got n=%0d at %0d want n=1 at 36", obs_done, obs_done_i);
      end
   endtask

   task automatic test_div0();
      clear_stim(); d0a[2] = 1;
      run_op(1, 0, "div0");
      checks++;
      if (obs_d0 != 1 || obs_d0_i != 5 || obs_wr != 0) begin
         errors++; $display("FAIL div0_pulse: got n=%0d at %0d wr=%0d want n=1 at 5 wr=0", obs_d0, obs_d0_i, obs_wr);
      end
   endtask

   task automatic test_timeout();
      clear_stim();
      run_op(1, 0, "timeout");
      checks++;
      if (obs_to != 1 || obs_to_i != 1 + TO + 1 || obs_wr != 0 || obs_d0 != 0) begin
         errors++; $display("FAIL timeout_pulse: got n=%0d at %0d wr=%0d d0=%0d want n=1 at %0d wr=0 d0=0",
                            obs_to, obs_to_i, obs_wr, obs_d0, TO + 2);
      end
   endtask

   task automatic test_crosstalk();
      clear_stim(); md[5] = 1; dd[10] = 1; d0a[10] = 1;
      run_op(1, 0, "crosstalk");
      checks++;
      if (obs_d0 != 1 || obs_done != 0 || obs_wr != 0) begin
         errors++; $display("FAIL crosstalk: got d0=%0d done=%0d wr=%0d want d0=1 done=0 wr=0", obs_d0, obs_done, obs_wr);
      end
      // Div0 during a MULT is ignored
      clear_stim(); d0a[3] = 1; md[6] = 1;
      run_op(0, 0, "mult_div0_ignored");
      checks++;
      if (obs_d0 != 0 || obs_done != 1) begin
         errors++; $display("FAIL mult_div0_ignored: got d0=%0d done=%0d want d0=0 done=1", obs_d0, obs_done);
      end
   endtask

   task automatic test_cancel();
      logic [11:0] act, exp;
      clear_stim(); ab[7] = 1; dd[7] = 1;
      run_op(1, 0, "abort_wait");
      checks++;
      if (obs_done + obs_d0 + obs_to + obs_wr != 0) begin
         errors++; $display("FAIL abort_pulses: got %0d pulses want 0", obs_done + obs_d0 + obs_to + obs_wr);
      end
      clear_stim(); md[0] = 1;
      run_op(0, 1, "abort_launch");
      // reset while in WAIT cycle 7
      bus.req_valid = 1; bus.req_op = 0; bus.hilo_rd = 1;
      @(posedge clock); #1;
      bus.req_valid = 0;
      repeat (8) @(posedge clock);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL busy_before_reset: got %b want 1", bus.busy);
      end
      bus.MultDone = 1;
      reset = 1;
      @(posedge clock); #1;
      reset = 0; bus.MultDone = 0;
      act = act_vec();
      exp = 12'b1000_0000_0000;
      checks++;
      if (act !== exp) begin
         errors++; $display("FAIL reset_mid_op: got %b want %b", act, exp);
      end
      sel_exp = 0;
      bus.hilo_rd = 0;
   endtask

   task automatic test_stall();
      logic [11:0] act;
      rd_mode = 1;
      clear_stim(); md[4] = 1;
      run_op(0, 0, "stall");
      checks++;
      if (obs_stall != 7) begin
         errors++; $display("FAIL stall_cycles: got %0d want 7", obs_stall);
      end
      bus.hilo_rd = 1;
      #1;
      act = act_vec();
      checks++;
      if (act[0] !== 1'b0 || act[11] !== 1'b1) begin
         errors++; $display("FAIL stall_idle: got stall=%b ready=%b want stall=0 ready=1", act[0], act[11]);
      end
      @(posedge clock); #1;
      rd_mode = 0;
   endtask

   task automatic test_back_to_back();
      clear_stim(); dd[0] = 1;
      run_op(1, 0, "b2b_div");
      clear_stim(); md[1] = 1;
      run_op(0, 0, "b2b_mult");
      clear_stim(); d0a[0] = 1;
      run_op(1, 0, "b2b_div0");
      clear_stim(); md[2] = 1;
      run_op(0, 0, "b2b_after_err");
   endtask

   task automatic test_random();
      bit op, ab_l;
      for (int n = 0; n < 30; n++) begin
         clear_stim();
         op = 1'($urandom_range(0, 1));
         ab_l = ($urandom_range(0, 9) == 0);
         for (int w = 0; w < TO; w++) begin
            md[w]  = ($urandom_range(0, 24) == 0);
            dd[w]  = ($urandom_range(0, 24) == 0);
            d0a[w] = ($urandom_range(0, 39) == 0);
            ab[w]  = ($urandom_range(0, 79) == 0);
         end
         run_op(op, ab_l, "random");
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div0();
      test_timeout();
      test_crosstalk();
      test_cancel();
      test_stall();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
